cbus_arbiter: RTL and testbench

Round-robin arbiter that shares the single cache/memory bus (cbus) between NUM_REQ cache-side requesters, typically the ICache and DCache miss/write-back ports. It sits between the caches and the memory-side cbus port of the core top level. A grant is held for a whole burst, and responses are routed back only to the granted requester. Fairness is rotating-priority, so neither cache can starve the other.

---
 rtl/common.sv | 21 ++
 rtl/cbus_arbiter_rr_pick.sv | 32 +++
 rtl/cbus_arbiter.sv | 82 ++++++++
 tb/tb_cbus_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared cbus field layout used by the caches, the core top level and the memory side.
package common;

   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [7:0]  len;
      logic [1:0]  burst;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first set request at prio, prio+1, ... mod NUM_REQ.
module rr_pick #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   prio_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   int               j;
   logic [IDX_W-1:0] cand;

   // Scan from the farthest offset down so the nearest-to-prio request wins last.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      cand    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = int'(prio_i) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         cand = IDX_W'(j);
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one cbus between NUM_REQ cache requesters; grant held for a burst.
module cbus_arbiter
   import common::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             reset_,
   input  cbus_req_t        ireqs  [NUM_REQ],
   output cbus_resp_t       oresps [NUM_REQ],
   output cbus_req_t        oreq,
   input  cbus_resp_t       iresp,
   output logic             dbg_busy_o,
   output logic [IDX_W-1:0] dbg_sel_o,
   output logic [IDX_W-1:0] dbg_prio_o
);

   typedef enum logic {IDLE, BUSY} state_e;
   typedef logic [IDX_W-1:0] idx_t;

   state_e             state_q, state_d;
   idx_t               sel_q, sel_d;
   idx_t               prio_q, prio_d;
   logic [NUM_REQ-1:0] req_vld;
   logic               pick_found;
   idx_t               pick_idx;

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) req_vld[k] = ireqs[k].valid;
   end

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (req_vld),
      .prio_i  (prio_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Outputs decode from registered state only, so async reset clears them without a clock.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      prio_d  = prio_q;
      oreq    = '0;
      for (int k = 0; k < NUM_REQ; k++) oresps[k] = '0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               sel_d   = pick_idx;
               state_d = BUSY;
            end
         end
         BUSY: begin
            oreq           = ireqs[sel_q];
            oresps[sel_q]  = iresp;
            if (oreq.valid && iresp.ready && iresp.last) begin
               state_d = IDLE;
               prio_d  = (sel_q == idx_t'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q <= IDLE;
         sel_q   <= '0;
         prio_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         prio_q  <= prio_d;
      end
   end

   assign dbg_busy_o = (state_q == BUSY);
   assign dbg_sel_o  = sel_q;
   assign dbg_prio_o = prio_q;

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter with two requesters; inputs change on negedge, checks at negedge+1.
module tb_cbus_arbiter;
   import common::*;

   logic       clk;
   logic       reset_;
   cbus_req_t  ireqs  [2];
   cbus_resp_t oresps [2];
   cbus_req_t  oreq;
   cbus_resp_t iresp;
   logic       dbg_busy;
   logic [0:0] dbg_sel;
   logic [0:0] dbg_prio;

   int checks   = 0;
   int failures = 0;

   cbus_arbiter #(.NUM_REQ(2)) dut (
      .clk        (clk),
      .reset_     (reset_),
      .ireqs      (ireqs),
      .oresps     (oresps),
      .oreq       (oreq),
      .iresp      (iresp),
      .dbg_busy_o (dbg_busy),
      .dbg_sel_o  (dbg_sel),
      .dbg_prio_o (dbg_prio)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   function automatic cbus_req_t mk_req(input logic wr, input logic [31:0] addr,
                                        input logic [7:0] len, input logic [31:0] data);
      cbus_req_t r;
      r          = '0;
      r.valid    = 1'b1;
      r.is_write = wr;
      r.size     = 3'd2;
      r.addr     = addr;
      r.strobe   = wr ? 4'hF : 4'h0;
      r.data     = data;
      r.len      = len;
      r.burst    = 2'd1;
      return r;
   endfunction

   task automatic do_reset();
      ireqs[0] = '0;
      ireqs[1] = '0;
      iresp    = '0;
      reset_   = 1'b1;
      #1 reset_ = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_ = 1'b1;
   endtask

   task automatic test_reset();
      ireqs[0] = mk_req(1'b0, 32'h100, 8'd0, 32'h0);
      ireqs[1] = '0;
      iresp    = '0;
      reset_   = 1'b1;
      #1 reset_ = 1'b0;
      @(negedge clk); #1;
      checks++;
      if (oreq !== '0) begin failures++; $display("FAIL reset_oreq: got %0h expected 0", oreq); end
      checks++;
      if (oresps[0] !== '0 || oresps[1] !== '0) begin
         failures++; $display("FAIL reset_oresps: got %0h/%0h expected 0/0", oresps[0], oresps[1]);
      end
      checks++;
      if (dbg_busy !== 1'b0 || dbg_sel !== 1'b0 || dbg_prio !== 1'b0) begin
         failures++; $display("FAIL reset_state: got busy=%b sel=%0d prio=%0d expected 0/0/0", dbg_busy, dbg_sel, dbg_prio);
      end
      @(negedge clk); #1;
      checks++;
      if (oreq.valid !== 1'b0) begin failures++; $display("FAIL reset_hold: got valid=%b expected 0", oreq.valid); end
      reset_ = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (oreq.valid !== 1'b1 || dbg_sel !== 1'b0 || oreq.addr !== 32'h100) begin
         failures++; $display("FAIL reset_grant: got valid=%b sel=%0d addr=%0h expected 1/0/100", oreq.valid, dbg_sel, oreq.addr);
      end
      iresp = '{ready: 1'b1, last: 1'b1, data: 32'h5};
      @(negedge clk);
      ireqs[0] = '0;
      iresp    = '0;
      #1;
      checks++;
      if (dbg_busy !== 1'b0 || dbg_prio !== 1'b1) begin
         failures++; $display("FAIL reset_done: got busy=%b prio=%0d expected 0/1", dbg_busy, dbg_prio);
      end
   endtask

   task automatic test_simultaneous();
      logic [0:0]  me;
      logic [0:0]  other;
      logic [31:0] exp_data;
      do_reset();
      @(negedge clk);
      ireqs[0] = mk_req(1'b0, 32'h1000, 8'd3, 32'h0);
      ireqs[1] = mk_req(1'b0, 32'h2000, 8'd3, 32'h0);
      #1;
      checks++;
      if (dbg_busy !== 1'b0 || oreq.valid !== 1'b0) begin
         failures++; $display("FAIL sim_bubble: got busy=%b valid=%b expected 0/0", dbg_busy, oreq.valid);
      end
      for (int t = 0; t < 2; t++) begin
         me    = 1'(t);
         other = ~me;
         for (int b = 0; b < 4; b++) begin
            exp_data = 32'h100 * 32'(t + 1) + 32'(b);
            @(negedge clk);
            iresp = '{ready: 1'b1, last: (b == 3), data: exp_data};
            #1;
            checks++;
            if (dbg_busy !== 1'b1 || dbg_sel !== me || oreq.addr !== 32'h1000 * 32'(t + 1)) begin
               failures++; $display("FAIL sim_grant t=%0d b=%0d: got busy=%b sel=%0d addr=%0h expected sel=%0d", t, b, dbg_busy, dbg_sel, oreq.addr, me);
            end
            checks++;
            if (oresps[me].data !== exp_data || oresps[me].ready !== 1'b1 || oresps[other] !== '0) begin
               failures++; $display("FAIL sim_resp t=%0d b=%0d: got %0h other=%0h expected data %0h other 0", t, b, oresps[me].data, oresps[other], exp_data);
            end
         end
         @(negedge clk);
         ireqs[me].valid = 1'b0;
         iresp           = '0;
         #1;
         checks++;
         if (dbg_busy !== 1'b0 || dbg_prio !== other) begin
            failures++; $display("FAIL sim_idle t=%0d: got busy=%b prio=%0d expected 0/%0d", t, dbg_busy, dbg_prio, other);
         end
      end
      ireqs[0] = mk_req(1'b0, 32'h1000, 8'd0, 32'h0);
      ireqs[1] = mk_req(1'b0, 32'h2000, 8'd0, 32'h0);
      @(negedge clk); #1;
      checks++;
      if (dbg_busy !== 1'b1 || dbg_sel !== 1'b0) begin
         failures++; $display("FAIL sim_regrant: got busy=%b sel=%0d expected 1/0", dbg_busy, dbg_sel);
      end
   endtask

   task automatic test_starvation();
      logic [0:0] exp_sel;
      do_reset();
      @(negedge clk);
      ireqs[0] = mk_req(1'b0, 32'h300, 8'd0, 32'h0);
      ireqs[1] = mk_req(1'b0, 32'h400, 8'd0, 32'h0);
      for (int t = 0; t < 4; t++) begin
         exp_sel = 1'(t % 2);
         @(negedge clk);
         iresp = '{ready: 1'b1, last: 1'b1, data: 32'(t)};
         #1;
         checks++;
         if (dbg_busy !== 1'b1 || dbg_sel !== exp_sel || oresps[exp_sel].ready !== 1'b1 || oresps[~exp_sel].ready !== 1'b0) begin
            failures++; $display("FAIL starve_grant t=%0d: got busy=%b sel=%0d expected sel=%0d", t, dbg_busy, dbg_sel, exp_sel);
         end
         @(negedge clk);
         iresp = '0;
         #1;
         checks++;
         if (dbg_busy !== 1'b0) begin
            failures++; $display("FAIL starve_dead t=%0d: got busy=%b expected 0", t, dbg_busy);
         end
      end
      ireqs[0] = '0;
      ireqs[1] = '0;
   endtask

   task automatic test_write_burst();
      logic       rdy_pat [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int         beat;
      logic [7:0] exp_byte;
      do_reset();
      @(negedge clk);
      ireqs[1] = mk_req(1'b1, 32'h800, 8'd3, 32'hA0);
      beat = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         exp_byte      = 8'hA0 + 8'(beat);
         ireqs[1].data = {24'h0, exp_byte};
         iresp         = '{ready: rdy_pat[c], last: rdy_pat[c] && (beat == 3), data: 32'h0};
         #1;
         checks++;
         if (oreq.data !== {24'h0, exp_byte} || oreq.is_write !== 1'b1 || oreq.valid !== 1'b1) begin
            failures++; $display("FAIL wr_data c=%0d: got data=%0h wr=%b expected %0h", c, oreq.data, oreq.is_write, exp_byte);
         end
         checks++;
         if (oresps[0].ready !== 1'b0 || oresps[1].ready !== rdy_pat[c]) begin
            failures++; $display("FAIL wr_ready c=%0d: got r0=%b r1=%b expected 0/%b", c, oresps[0].ready, oresps[1].ready, rdy_pat[c]);
         end
         if (rdy_pat[c]) beat++;
      end
      @(negedge clk);
      ireqs[1] = '0;
      iresp    = '0;
      #1;
      checks++;
      if (dbg_busy !== 1'b0 || dbg_prio !== 1'b0) begin
         failures++; $display("FAIL wr_end: got busy=%b prio=%0d expected 0/0", dbg_busy, dbg_prio);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      @(negedge clk);
      ireqs[0] = mk_req(1'b0, 32'h900, 8'd0, 32'h0);
      @(negedge clk);
      iresp = '{ready: 1'b1, last: 1'b1, data: 32'h0};
      @(negedge clk);
      ireqs[0] = '0;
      ireqs[1] = mk_req(1'b0, 32'hA00, 8'd3, 32'h0);
      iresp    = '0;
      #1;
      checks++;
      if (dbg_prio !== 1'b1) begin failures++; $display("FAIL ar_prio_before: got %0d expected 1", dbg_prio); end
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         iresp = '{ready: 1'b1, last: 1'b0, data: 32'(b)};
      end
      @(negedge clk);
      iresp = '{ready: 1'b1, last: 1'b0, data: 32'h2};
      #1;
      checks++;
      if (oreq.valid !== 1'b1 || dbg_sel !== 1'b1) begin
         failures++; $display("FAIL ar_midburst: got valid=%b sel=%0d expected 1/1", oreq.valid, dbg_sel);
      end
      #1 reset_ = 1'b0;
      #1;
      checks++;
      if (oreq !== '0 || oresps[0] !== '0 || oresps[1] !== '0) begin
         failures++; $display("FAIL ar_immediate: got oreq=%0h r1=%0h expected 0/0", oreq, oresps[1]);
      end
      checks++;
      if (dbg_busy !== 1'b0 || dbg_prio !== 1'b0 || dbg_sel !== 1'b0) begin
         failures++; $display("FAIL ar_state: got busy=%b sel=%0d prio=%0d expected 0/0/0", dbg_busy, dbg_sel, dbg_prio);
      end
      iresp    = '0;
      ireqs[0] = mk_req(1'b0, 32'hB00, 8'd0, 32'h0);
      @(negedge clk);
      reset_ = 1'b1;
      @(negedge clk); #1;
      checks++;
      if (dbg_busy !== 1'b1 || dbg_sel !== 1'b0 || oreq.addr !== 32'hB00) begin
         failures++; $display("FAIL ar_regrant: got busy=%b sel=%0d addr=%0h expected 1/0/b00", dbg_busy, dbg_sel, oreq.addr);
      end
   endtask

   task automatic test_single_beat();
      do_reset();
      @(negedge clk);
      ireqs[0] = mk_req(1'b0, 32'h500, 8'd0, 32'h0);
      @(negedge clk);
      iresp = '{ready: 1'b1, last: 1'b1, data: 32'hDEADBEEF};
      #1;
      checks++;
      if (dbg_busy !== 1'b1 || oresps[0].data !== 32'hDEADBEEF || oresps[0].last !== 1'b1) begin
         failures++; $display("FAIL single_resp: got busy=%b data=%0h last=%b expected 1/deadbeef/1", dbg_busy, oresps[0].data, oresps[0].last);
      end
      @(negedge clk);
      ireqs[0] = '0;
      iresp    = '0;
      #1;
      checks++;
      if (dbg_busy !== 1'b0 || dbg_prio !== 1'b1) begin
         failures++; $display("FAIL single_len: got busy=%b prio=%0d expected 0/1", dbg_busy, dbg_prio);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      @(negedge clk);
      ireqs[0] = mk_req(1'b0, 32'h600, 8'd0, 32'h0);
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         iresp = '{ready: 1'b1, last: 1'b1, data: 32'h0};
         #1;
         checks++;
         if (dbg_busy !== 1'b1 || dbg_sel !== 1'b0) begin
            failures++; $display("FAIL b2b_grant t=%0d: got busy=%b sel=%0d expected 1/0", t, dbg_busy, dbg_sel);
         end
         @(negedge clk);
         iresp = '0;
         #1;
         checks++;
         if (dbg_busy !== 1'b0 || oreq.valid !== 1'b0) begin
            failures++; $display("FAIL b2b_dead t=%0d: got busy=%b valid=%b expected 0/0", t, dbg_busy, oreq.valid);
         end
      end
      ireqs[0] = '0;
   endtask

   initial begin
      ireqs[0] = '0;
      ireqs[1] = '0;
      iresp    = '0;
      reset_   = 1'b1;
      test_reset();
      test_simultaneous();
      test_starvation();
      test_write_burst();
      test_async_reset();
      test_single_beat();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
